cpu_mem_responder: RTL and testbench
====================================

// Module: cpu_mem_responder
// PURPOSE
// - Memory-side responder for the core's instruction port and data port. It accepts fetch,
//   load and store requests, returns instructions and load data after a fixed latency, and
//   acknowledges stores.
// - Sits between the 5-stage core and the backing RAM. Also serves as the core's bench memory model.
// - Three independent channels (IFETCH, DREAD, DWRITE) share one word-addressed array.
// PARAMETERS
// - ADDR_WIDTH   64             request address width
// - DATA_WIDTH   64             data-bus width; one array word
// - INST_WIDTH   32             instruction width
// - DEPTH_LOG2   16             log2 of array depth in 64-bit words
// - BASE_ADDR    64'h8000_0000  byte address of word 0
// - RD_LAT       1              extra wait cycles for fetch/load responses (0..15)
// - WR_LAT       1              extra wait cycles for store acknowledge (0..15)
// PORTS
// - clk           in   1           clock
// - rst           in   1           reset, synchronous, active-high
// - inst_req      in   1           fetch request valid (held by core until inst_valid)
// - inst_addr     in   ADDR_WIDTH  fetch byte address
// - inst_valid    out  1           fetch response pulse
// - inst_data     out  INST_WIDTH  fetched instruction
// - dr_req        in   1           load request valid (held until dr_valid)
// - dr_addr       in   ADDR_WIDTH  load byte address
// - dr_valid      out  1           load response pulse
// - dr_data       out  DATA_WIDTH  load data (full aligned word)
// - dw_req        in   1           store request valid (held until dw_ready)
// - dw_addr       in   ADDR_WIDTH  store byte address
// - dw_data       in   DATA_WIDTH  store data
// - dw_mask       in   8           store byte-enable; bit i selects byte lane i
// - dw_ready      out  1           store acknowledge pulse
// BEHAVIOUR
// - Per-channel FSM: IDLE -> WAIT -> RESP -> IDLE.
//   - In IDLE with req=1, the FSM captures addr (and data/mask for stores), loads the counter
//     with LAT, and moves to WAIT.
//   - In WAIT, the counter decrements each cycle. At 0 the FSM moves to RESP.
//   - RESP lasts one cycle: the valid/ready output is 1 and the FSM returns to IDLE.
//   - Request accepted in cycle t -> response in cycle t+2+LAT. With LAT=0, response is at t+2.
// - In RESP, req is ignored even if still high; it is not re-accepted.
//   A new request is accepted only in IDLE. This keeps one response per held request.
// - Index = (addr - BASE_ADDR) >> 3, truncated to DEPTH_LOG2 bits. Address bits [2:0] are
//   ignored for data.
// - Fetch returns word[63:32] if addr[2]=1, otherwise word[31:0].
// - Array read is performed on entry to RESP; data outputs are registered.
// - Store commits to the array in its RESP cycle. Byte lane i is written only if dw_mask[i]=1.
//   dw_mask=0 acknowledges without writing.
// - Same-cycle read RESP and store RESP to the same word: the read returns the OLD word.
//   The new value is visible to reads whose RESP cycle is later.
// - Out-of-range addresses (addr < BASE_ADDR or addr >= BASE_ADDR + 8<<DEPTH_LOG2):
//   - reads return 0;
//   - stores are acknowledged with no array write.
// - Reset values: inst_valid=dr_valid=dw_ready=0, inst_data=dr_data=0, FSMs in IDLE,
//   counters 0. Array contents are not reset.
// - rst asserted mid-operation: pending responses are dropped with no pulse, and pending
//   stores are not committed.
// - Data outputs hold their last value between pulses.
// CONFIGURATION
// - MEMRSP_OOR_ERR_EN defined:
//   - adds output ports inst_err, dr_err, dw_err (each 1 bit, reset 0);
//   - each err pulses together with its channel's valid/ready when the captured address was
//     out of range;
//   - an out-of-range store is still not written.
// - MEMRSP_OOR_ERR_EN undefined: the err ports are absent. Out-of-range behaviour is otherwise
//   identical.
// TESTING
// - RD_LAT=1; preload word0=64'h0000_0013_0000_0093; inst_req, addr 0x8000_0004 at t
//   -> inst_valid=1 at t+3, inst_data=32'h0000_0013, single pulse.
// - Store addr 0x8000_0008, data 64'h1122_3344_5566_7788, mask 8'h0F, over prior 0
//   -> dw_ready pulse at t+2+WR_LAT; a later load of the same word returns 64'h0000_0000_5566_7788.
// - Load and store to the same word with RESP cycles aligned -> dr_data=old word;
//   the next load returns the new word.
// - dr_req held high for 10 cycles with RD_LAT=0 -> dr_valid pulses at t+2, t+5, t+8:
//   no back-to-back pulses, one per IDLE acceptance.
// - rst pulsed in the WAIT state of a store -> no dw_ready, array word unchanged,
//   all outputs 0 the cycle after rst.
// - MEMRSP_OOR_ERR_EN defined; load addr 0x7FFF_FFF8 -> dr_valid=1, dr_err=1, dr_data=0.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - fixed-latency fetch/load/store responder over one shared word array
// Optional MEMRSP_OOR_ERR_EN adds per-channel out-of-range error pulses.
module cpu_mem_responder #(
    parameter int              ADDR_WIDTH = 64,
    parameter int              DATA_WIDTH = 64,
    parameter int              INST_WIDTH = 32,
    parameter int              DEPTH_LOG2 = 16,
    parameter logic [63:0]     BASE_ADDR  = 64'h8000_0000,
    parameter int              RD_LAT     = 1,
    parameter int              WR_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_data,
    input  logic                  dr_req,
    input  logic [ADDR_WIDTH-1:0] dr_addr,
    output logic                  dr_valid,
    output logic [DATA_WIDTH-1:0] dr_data,
    input  logic                  dw_req,
    input  logic [ADDR_WIDTH-1:0] dw_addr,
    input  logic [DATA_WIDTH-1:0] dw_data,
    input  logic [7:0]            dw_mask,
`ifdef MEMRSP_OOR_ERR_EN
    output logic                  inst_err,
    output logic                  dr_err,
    output logic                  dw_err,
`endif
    output logic                  dw_ready
);
    localparam int NCH = 3;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q [NCH];
    state_t                state_d [NCH];
    logic [3:0]            cnt_q   [NCH];
    logic [3:0]            cnt_d   [NCH];
    logic [DEPTH_LOG2-1:0] idx_q   [NCH];
    logic [DEPTH_LOG2-1:0] idx_d   [NCH];
    logic                  oor_q   [NCH];
    logic                  oor_d   [NCH];
    logic                  req     [NCH];
    logic [ADDR_WIDTH-1:0] addr    [NCH];
    logic [3:0]            lat     [NCH];

    logic                  inst_hi_q, inst_hi_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            wmask_q, wmask_d;
    logic [INST_WIDTH-1:0] inst_data_q, inst_data_d;
    logic [DATA_WIDTH-1:0] dr_data_q, dr_data_d;
    logic [DATA_WIDTH-1:0] inst_word, dr_word;
    logic                  dw_commit;

    function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE;
        return (a < BASE) || ((off >> (DEPTH_LOG2 + 3)) != '0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE;
        return off[DEPTH_LOG2+2:3];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] nw,
                                                    input logic [7:0]            m);
        logic [DATA_WIDTH-1:0] r;
        r = old;
        for (int i = 0; i < 8; i++)
            if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        req[0] = inst_req; addr[0] = inst_addr; lat[0] = 4'(RD_LAT);
        req[1] = dr_req;   addr[1] = dr_addr;   lat[1] = 4'(RD_LAT);
        req[2] = dw_req;   addr[2] = dw_addr;   lat[2] = 4'(WR_LAT);
    end

    assign dw_commit = (state_q[2] == S_RESP) && !oor_q[2] && !rst;

    // A store committing on the same edge a read samples the array must be seen by that read.
    always_comb begin
        inst_word = mem[idx_q[0]];
        dr_word   = mem[idx_q[1]];
        if (dw_commit && idx_q[2] == idx_q[0]) inst_word = merge(inst_word, wdata_q, wmask_q);
        if (dw_commit && idx_q[2] == idx_q[1]) dr_word   = merge(dr_word, wdata_q, wmask_q);
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            idx_d[c]   = idx_q[c];
            oor_d[c]   = oor_q[c];
            case (state_q[c])
                S_IDLE: if (req[c]) begin
                    state_d[c] = S_WAIT;
                    cnt_d[c]   = lat[c];
                    idx_d[c]   = addr_idx(addr[c]);
                    oor_d[c]   = addr_oor(addr[c]);
                end
                S_WAIT: begin
                    if (cnt_q[c] == 4'd0) state_d[c] = S_RESP;
                    else                  cnt_d[c]   = cnt_q[c] - 4'd1;
                end
                default: state_d[c] = S_IDLE;
            endcase
        end
        inst_hi_d = inst_hi_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        if (state_q[0] == S_IDLE && inst_req) inst_hi_d = inst_addr[2];
        if (state_q[2] == S_IDLE && dw_req) begin
            wdata_d = dw_data;
            wmask_d = dw_mask;
        end
        inst_data_d = inst_data_q;
        dr_data_d   = dr_data_q;
        if (state_q[0] == S_WAIT && cnt_q[0] == 4'd0)
            inst_data_d = oor_q[0] ? '0 :
                          (inst_hi_q ? inst_word[INST_WIDTH +: INST_WIDTH] : inst_word[0 +: INST_WIDTH]);
        if (state_q[1] == S_WAIT && cnt_q[1] == 4'd0)
            dr_data_d = oor_q[1] ? '0 : dr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= S_IDLE;
                cnt_q[c]   <= 4'd0;
                idx_q[c]   <= '0;
                oor_q[c]   <= 1'b0;
            end
            inst_hi_q   <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            inst_data_q <= '0;
            dr_data_q   <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                idx_q[c]   <= idx_d[c];
                oor_q[c]   <= oor_d[c];
            end
            inst_hi_q   <= inst_hi_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            inst_data_q <= inst_data_d;
            dr_data_q   <= dr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dw_commit)
            for (int i = 0; i < 8; i++)
                if (wmask_q[i]) mem[idx_q[2]][8*i +: 8] <= wdata_q[8*i +: 8];
    end

    assign inst_valid = (state_q[0] == S_RESP);
    assign dr_valid   = (state_q[1] == S_RESP);
    assign dw_ready   = (state_q[2] == S_RESP);
    assign inst_data  = inst_data_q;
    assign dr_data    = dr_data_q;
`ifdef MEMRSP_OOR_ERR_EN
    assign inst_err   = inst_valid && oor_q[0];
    assign dr_err     = dr_valid && oor_q[1];
    assign dw_err     = dw_ready && oor_q[2];
`endif
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - directed self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;
    localparam int RD_LAT = 1;
    localparam int WR_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, dr_req, dw_req;
    logic [63:0] inst_addr, dr_addr, dw_addr, dw_data;
    logic [7:0]  dw_mask;
    logic        inst_valid, dr_valid, dw_ready;
    logic [31:0] inst_data;
    logic [63:0] dr_data;
`ifdef MEMRSP_OOR_ERR_EN
    logic        inst_err, dr_err, dw_err;
    logic        b_inst_err, b_dr_err, b_dw_err;
`endif
    logic        b_dr_req;
    logic        b_inst_valid, b_dr_valid, b_dw_ready;
    logic [31:0] b_inst_data;
    logic [63:0] b_dr_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_mem_responder #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid), .inst_data(inst_data),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_valid(dr_valid), .dr_data(dr_data),
        .dw_req(dw_req), .dw_addr(dw_addr), .dw_data(dw_data), .dw_mask(dw_mask),
`ifdef MEMRSP_OOR_ERR_EN
        .inst_err(inst_err), .dr_err(dr_err), .dw_err(dw_err),
`endif
        .dw_ready(dw_ready)
    );

    cpu_mem_responder #(.RD_LAT(0), .WR_LAT(0)) u_b2b (
        .clk(clk), .rst(rst),
        .inst_req(1'b0), .inst_addr(64'h8000_0000), .inst_valid(b_inst_valid), .inst_data(b_inst_data),
        .dr_req(b_dr_req), .dr_addr(64'h8000_0000), .dr_valid(b_dr_valid), .dr_data(b_dr_data),
        .dw_req(1'b0), .dw_addr(64'h8000_0000), .dw_data(64'h0), .dw_mask(8'h00),
`ifdef MEMRSP_OOR_ERR_EN
        .inst_err(b_inst_err), .dr_err(b_dr_err), .dw_err(b_dw_err),
`endif
        .dw_ready(b_dw_ready)
    );

    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                            input string nm);
        int n = 0;
        @(negedge clk);
        dw_req = 1'b1; dw_addr = a; dw_data = d; dw_mask = m;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dw_ready) begin n = k; break; end
        end
        dw_req = 1'b0;
        n_checks++;
        if (n !== 2 + WR_LAT) begin
            n_fail++;
            $display("FAIL %s store latency: got %0d want %0d", nm, n, 2 + WR_LAT);
        end
        @(negedge clk);
        n_checks++;
        if (dw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dw_ready single pulse: got %b want 0", nm, dw_ready);
        end
    endtask

    task automatic do_load(input logic [63:0] a, input logic [63:0] exp_d, input logic exp_err,
                           input string nm);
        int n = 0;
        logic [63:0] got = '0;
        logic        got_err = 1'b0;
        @(negedge clk);
        dr_req = 1'b1; dr_addr = a;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dr_valid) begin
                n = k; got = dr_data;
`ifdef MEMRSP_OOR_ERR_EN
                got_err = dr_err;
`else
                got_err = exp_err;
`endif
                break;
            end
        end
        dr_req = 1'b0;
        n_checks++;
        if (n !== 2 + RD_LAT) begin
            n_fail++;
            $display("FAIL %s load latency: got %0d want %0d", nm, n, 2 + RD_LAT);
        end
        n_checks++;
        if (got !== exp_d) begin
            n_fail++;
            $display("FAIL %s dr_data: got %h want %h", nm, got, exp_d);
        end
`ifdef MEMRSP_OOR_ERR_EN
        n_checks++;
        if (got_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s dr_err: got %b want %b", nm, got_err, exp_err);
        end
`endif
        @(negedge clk);
        n_checks++;
        if (dr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dr_valid single pulse: got %b want 0", nm, dr_valid);
        end
    endtask

    task automatic do_fetch(input logic [63:0] a, input logic [31:0] exp_i, input string nm);
        int n = 0;
        logic [31:0] got = '0;
        @(negedge clk);
        inst_req = 1'b1; inst_addr = a;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (inst_valid) begin n = k; got = inst_data; break; end
        end
        inst_req = 1'b0;
        n_checks++;
        if (n !== 2 + RD_LAT) begin
            n_fail++;
            $display("FAIL %s fetch latency: got %0d want %0d", nm, n, 2 + RD_LAT);
        end
        n_checks++;
        if (got !== exp_i) begin
            n_fail++;
            $display("FAIL %s inst_data: got %h want %h", nm, got, exp_i);
        end
        @(negedge clk);
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s inst_valid single pulse: got %b want 0", nm, inst_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_req = 0; dr_req = 0; dw_req = 0; b_dr_req = 0;
        inst_addr = '0; dr_addr = '0; dw_addr = '0; dw_data = '0; dw_mask = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({inst_valid, dr_valid, dw_ready, inst_data, dr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b%b%b %h %h want all 0",
                     inst_valid, dr_valid, dw_ready, inst_data, dr_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        do_store(64'h8000_0000, 64'h0000_0013_0000_0093, 8'hFF, "preload_w0");
        do_fetch(64'h8000_0004, 32'h0000_0013, "fetch_hi");
        do_fetch(64'h8000_0000, 32'h0000_0093, "fetch_lo");
    endtask

    task automatic test_store_mask();
        do_store(64'h8000_0008, 64'h0, 8'hFF, "clear_w1");
        do_store(64'h8000_0008, 64'h1122_3344_5566_7788, 8'h0F, "mask_0f");
        do_load(64'h8000_0008, 64'h0000_0000_5566_7788, 1'b0, "load_w1");
        do_load(64'h8000_000C, 64'h0000_0000_5566_7788, 1'b0, "load_w1_unaligned");
        do_store(64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, "mask_00");
        do_load(64'h8000_0008, 64'h0000_0000_5566_7788, 1'b0, "load_after_mask0");
    endtask

    task automatic test_aligned_rw();
        int          nr = 0;
        int          nw = 0;
        logic [63:0] got = '0;
        @(negedge clk);
        dr_req = 1'b1; dr_addr = 64'h8000_0008;
        dw_req = 1'b1; dw_addr = 64'h8000_0008; dw_data = 64'hAAAA_AAAA_AAAA_AAAA; dw_mask = 8'hF0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (dr_valid && nr == 0) begin nr = k; got = dr_data; dr_req = 1'b0; end
            if (dw_ready && nw == 0) begin nw = k; dw_req = 1'b0; end
            if (nr != 0 && nw != 0) break;
        end
        dr_req = 1'b0; dw_req = 1'b0;
        n_checks++;
        if (nr !== nw || nr !== 2 + RD_LAT) begin
            n_fail++;
            $display("FAIL aligned resp cycles: got rd %0d wr %0d want %0d", nr, nw, 2 + RD_LAT);
        end
        n_checks++;
        if (got !== 64'h0000_0000_5566_7788) begin
            n_fail++;
            $display("FAIL aligned old word: got %h want %h", got, 64'h0000_0000_5566_7788);
        end
        do_load(64'h8000_0008, 64'hAAAA_AAAA_5566_7788, 1'b0, "aligned_new_word");
    endtask

    task automatic test_bounds();
        do_store(64'h8007_FFF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, "top_word_store");
        do_load(64'h8007_FFF8, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, "top_word_load");
        do_store(64'h8008_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "oor_store");
        do_load(64'h8000_0000, 64'h0000_0013_0000_0093, 1'b0, "w0_after_oor_store");
        do_load(64'h7FFF_FFF8, 64'h0, 1'b1, "oor_load_low");
        do_load(64'h8000_0000, 64'h0000_0013_0000_0093, 1'b0, "w0_reload");
        do_load(64'h8008_0000, 64'h0, 1'b1, "oor_load_high");
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        do_store(64'h8000_0010, 64'h5555_5555_5555_5555, 8'hFF, "w2_store");
        do_load(64'h8000_0008, 64'hAAAA_AAAA_5566_7788, 1'b0, "dr_data_nonzero");
        @(negedge clk);
        dw_req = 1'b1; dw_addr = 64'h8000_0010; dw_data = 64'h9999_9999_9999_9999; dw_mask = 8'hFF;
        @(negedge clk);
        rst = 1'b1; dw_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({inst_valid, dr_valid, dw_ready, inst_data, dr_data} !== '0) begin
            n_fail++;
            $display("FAIL mid reset outputs: got %b%b%b %h %h want all 0",
                     inst_valid, dr_valid, dw_ready, inst_data, dr_data);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            seen = seen | dw_ready;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mid reset dropped ack: got %b want 0", seen);
        end
        do_load(64'h8000_0010, 64'h5555_5555_5555_5555, 1'b0, "w2_unchanged");
    endtask

    task automatic test_back_to_back();
        logic [10:0] pulses = '0;
        @(negedge clk);
        b_dr_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            pulses[k] = b_dr_valid;
        end
        b_dr_req = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (pulses !== 11'b001_0010_0100) begin
            n_fail++;
            $display("FAIL back_to_back pulse map: got %b want %b", pulses, 11'b001_0010_0100);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_mask();
        test_aligned_rw();
        test_bounds();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
